// File: rtl/mem_port_responder_if.sv
// mem_port_responder_if: bundles the CPU fetch port, the CPU load/store port
// and the word-wide backing-memory port seen by mem_port_responder.
// The slave modport is the responder's view; master is the CPU/memory side.
interface mem_port_responder_if;
    // Instruction fetch port
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;

    // Load/store port
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;

    // Backing memory port
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  instr_read, instr_mem_address,
        output instr_mem_resp, instr_mem_rdata,
        input  data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        output data_mem_resp, data_mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output instr_read, instr_mem_address,
        input  instr_mem_resp, instr_mem_rdata,
        output data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        input  data_mem_resp, data_mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_port_responder.sv
// mem_port_responder: arbitrates held fetch and load/store requests onto one
// word-wide backing-memory port and returns one-cycle responses with
// registered read data. Every output is a register (Moore style).
// Optional feature: define MEM_PORT_INSTR_HOLD_EN to add a one-entry
// instruction hold register that answers repeated fetches without pmem.
module mem_port_responder (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INSTR  = 3'd1,
        DATA   = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
`ifdef MEM_PORT_INSTR_HOLD_EN
        , HIT  = 3'd5
`endif
    } state_t;

    state_t      state;
    logic        last_grant_data;

    logic        instr_resp_reg;
    logic [31:0] instr_rdata_reg;
    logic        data_resp_reg;
    logic [31:0] data_rdata_reg;

    logic        pmem_read_reg;
    logic        pmem_write_reg;
    logic [31:0] pmem_address_reg;
    logic [31:0] pmem_wdata_reg;
    logic [3:0]  pmem_mbe_reg;

    logic        instr_pending;
    logic        data_pending;
    logic        grant_data;
    logic        unused_addr_bits;

`ifdef MEM_PORT_INSTR_HOLD_EN
    logic        hold_valid;
    logic [29:0] hold_addr;
    logic [31:0] hold_data;
    logic        hold_hit;
    logic        hold_kill;
`endif

    assign instr_pending = bus.instr_read;
    assign data_pending  = bus.data_read | bus.data_write;

    // Data wins unless a fetch is also pending and data was granted last time.
    assign grant_data = data_pending & (~instr_pending | ~last_grant_data);

    // Byte offsets never reach the word-wide backing port.
    assign unused_addr_bits = ^{bus.instr_mem_address[1:0], bus.data_mem_address[1:0]};

`ifdef MEM_PORT_INSTR_HOLD_EN
    assign hold_hit = hold_valid & (hold_addr == bus.instr_mem_address[31:2]);
`endif

    assign bus.instr_mem_resp  = instr_resp_reg;
    assign bus.instr_mem_rdata = instr_rdata_reg;
    assign bus.data_mem_resp   = data_resp_reg;
    assign bus.data_mem_rdata  = data_rdata_reg;
    assign bus.pmem_read       = pmem_read_reg;
    assign bus.pmem_write      = pmem_write_reg;
    assign bus.pmem_address    = pmem_address_reg;
    assign bus.pmem_wdata      = pmem_wdata_reg;
    assign bus.pmem_mbe        = pmem_mbe_reg;

    // Single FSM: arbitration, backing-port drive and CPU responses, all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            last_grant_data  <= 1'b0;
            instr_resp_reg   <= 1'b0;
            instr_rdata_reg  <= 32'h0;
            data_resp_reg    <= 1'b0;
            data_rdata_reg   <= 32'h0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= 32'h0;
            pmem_wdata_reg   <= 32'h0;
            pmem_mbe_reg     <= 4'h0;
`ifdef MEM_PORT_INSTR_HOLD_EN
            hold_valid       <= 1'b0;
            hold_addr        <= 30'h0;
            hold_data        <= 32'h0;
            hold_kill        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state            <= DATA;
                        pmem_address_reg <= {bus.data_mem_address[31:2], 2'b00};
                        if (bus.data_write) begin
                            pmem_write_reg <= 1'b1;
                            pmem_wdata_reg <= bus.data_mem_wdata;
                            pmem_mbe_reg   <= bus.data_mbe;
                        end else begin
                            pmem_read_reg  <= 1'b1;
                            pmem_mbe_reg   <= 4'hF;
                        end
                    end else if (instr_pending) begin
`ifdef MEM_PORT_INSTR_HOLD_EN
                        if (hold_hit) begin
                            state           <= HIT;
                            instr_resp_reg  <= 1'b1;
                            instr_rdata_reg <= hold_data;
                        end else
`endif
                        begin
                            state            <= INSTR;
                            pmem_read_reg    <= 1'b1;
                            pmem_mbe_reg     <= 4'hF;
                            pmem_address_reg <= {bus.instr_mem_address[31:2], 2'b00};
                        end
                    end
                end

                INSTR: begin
                    if (bus.pmem_resp) begin
                        state            <= RESP_I;
                        instr_resp_reg   <= 1'b1;
                        instr_rdata_reg  <= bus.pmem_rdata;
                        pmem_read_reg    <= 1'b0;
                        pmem_address_reg <= 32'h0;
                        pmem_mbe_reg     <= 4'h0;
`ifdef MEM_PORT_INSTR_HOLD_EN
                        hold_addr        <= pmem_address_reg[31:2];
                        hold_data        <= bus.pmem_rdata;
`endif
                    end
                end

                DATA: begin
                    if (bus.pmem_resp) begin
                        state         <= RESP_D;
                        data_resp_reg <= 1'b1;
                        if (pmem_read_reg) begin
                            data_rdata_reg <= bus.pmem_rdata;
                        end
                        pmem_read_reg    <= 1'b0;
                        pmem_write_reg   <= 1'b0;
                        pmem_address_reg <= 32'h0;
                        pmem_wdata_reg   <= 32'h0;
                        pmem_mbe_reg     <= 4'h0;
`ifdef MEM_PORT_INSTR_HOLD_EN
                        hold_kill <= pmem_write_reg & hold_valid &
                                     (hold_addr == pmem_address_reg[31:2]);
`endif
                    end
                end

                RESP_I: begin
                    instr_resp_reg  <= 1'b0;
                    last_grant_data <= 1'b0;
                    state           <= IDLE;
`ifdef MEM_PORT_INSTR_HOLD_EN
                    hold_valid      <= 1'b1;
`endif
                end

                RESP_D: begin
                    data_resp_reg   <= 1'b0;
                    last_grant_data <= 1'b1;
                    state           <= IDLE;
`ifdef MEM_PORT_INSTR_HOLD_EN
                    if (hold_kill) begin
                        hold_valid <= 1'b0;
                    end
                    hold_kill <= 1'b0;
`endif
                end

`ifdef MEM_PORT_INSTR_HOLD_EN
                HIT: begin
                    instr_resp_reg  <= 1'b0;
                    last_grant_data <= 1'b0;
                    state           <= IDLE;
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_responder.sv
// tb_mem_port_responder: randomized self-checking bench. A behavioural
// backing memory answers pmem requests with random latency; a reference
// model (word memory, grant history, hold-register contents) predicts every
// CPU response, its latency and the number of backing accesses.
module tb_mem_port_responder;
    logic clk;
    logic rst;

    mem_port_responder_if bus();

    mem_port_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MEM_PORT_INSTR_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    int test_count = 0;
    int fail_count = 0;

    // Backing memory environment state
    logic [31:0] pmem_mem [logic [29:0]];
    int          fixed_lat = 0;
    int          pmem_count = 0;
    int          pmem_last_lat = 0;
    logic [31:0] pmem_last_addr = 32'h0;
    logic [31:0] pmem_last_wdata = 32'h0;
    logic [3:0]  pmem_last_mbe = 4'h0;
    bit          pmem_last_write = 1'b0;

    // Reference model state
    logic [31:0] ref_mem [logic [29:0]];
    bit          model_last_data = 1'b0;
    bit          hold_valid = 1'b0;
    logic [29:0] hold_word = 30'h0;

    logic [31:0] pool [8] = '{32'h60, 32'h64, 32'h68, 32'h0,
                             32'h1000, 32'h1004, 32'h2000, 32'h3000};

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, %0d tests run, %0d failed", test_count, fail_count);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {~w[15:0], w[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] pmem_peek(input logic [29:0] w);
        return pmem_mem.exists(w) ? pmem_mem[w] : init_word(w);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_instr_resp"}, 32'(bus.instr_mem_resp), 32'd0);
        checkOutput({tag, "_instr_rdata"}, bus.instr_mem_rdata, 32'd0);
        checkOutput({tag, "_data_resp"}, 32'(bus.data_mem_resp), 32'd0);
        checkOutput({tag, "_data_rdata"}, bus.data_mem_rdata, 32'd0);
        checkOutput({tag, "_pmem_rw"}, 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
        checkOutput({tag, "_pmem_address"}, bus.pmem_address, 32'd0);
        checkOutput({tag, "_pmem_wdata"}, bus.pmem_wdata, 32'd0);
        checkOutput({tag, "_pmem_mbe"}, 32'(bus.pmem_mbe), 32'd0);
    endtask

    task automatic clearInputs();
        bus.instr_read        = 1'b0;
        bus.instr_mem_address = 32'h0;
        bus.data_read         = 1'b0;
        bus.data_write        = 1'b0;
        bus.data_mbe          = 4'h0;
        bus.data_mem_address  = 32'h0;
        bus.data_mem_wdata    = 32'h0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        clearInputs();
        model_last_data = 1'b0;
        hold_valid      = 1'b0;
        @(negedge clk);
        checkIdle("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Backing memory: random (or forced) latency, one-cycle resp pulse,
    // records each access so rounds can check what the DUT put on the bus.
    initial begin : pmem_model
        int remaining;
        remaining = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = $urandom;
            if (!rst || !(bus.pmem_read || bus.pmem_write)) begin
                remaining = 0;
            end else begin
                if (remaining == 0) begin
                    remaining       = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
                    pmem_last_lat   = remaining;
                    pmem_count++;
                    pmem_last_addr  = bus.pmem_address;
                    pmem_last_wdata = bus.pmem_wdata;
                    pmem_last_mbe   = bus.pmem_mbe;
                    pmem_last_write = bus.pmem_write;
                end
                if (remaining == 1) begin
                    if (pmem_last_write) begin
                        pmem_mem[pmem_last_addr[31:2]] =
                            merge(pmem_peek(pmem_last_addr[31:2]), pmem_last_wdata, pmem_last_mbe);
                    end else begin
                        bus.pmem_rdata = pmem_peek(pmem_last_addr[31:2]);
                    end
                    bus.pmem_resp = 1'b1;
                    remaining     = 0;
                end else begin
                    remaining--;
                end
            end
        end
    end

    // One round: issue a fetch, a data access or both, hold them until their
    // responses, and compare everything against the reference model.
    task automatic applyStimulus(input bit do_i, input logic [31:0] i_addr,
                                 input bit do_d, input bit d_wr, input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata, input logic [3:0] d_mbe);
        bit          i_done, d_done, i_hit;
        int          cyc, pm_before, exp_pm;
        logic [29:0] iw, dw;
        iw = i_addr[31:2];
        dw = d_addr[31:2];
        @(posedge clk);
        #1;
        bus.instr_read        = do_i;
        bus.instr_mem_address = i_addr;
        bus.data_write        = do_d & d_wr;
        bus.data_read         = do_d & (~d_wr | 1'($urandom_range(0, 1)));
        bus.data_mem_address  = d_addr;
        bus.data_mem_wdata    = d_wdata;
        bus.data_mbe          = d_mbe;
        pm_before = pmem_count;
        exp_pm    = 0;
        i_done    = !do_i;
        d_done    = !do_d;
        cyc       = 0;
        while (!(i_done && d_done) && cyc < 60) begin
            @(negedge clk);
            checkOutput("resp_exclusive", 32'(bus.instr_mem_resp & bus.data_mem_resp), 32'd0);
            if (!i_done && !d_done && (bus.instr_mem_resp || bus.data_mem_resp)) begin
                checkOutput("grant_order", 32'(bus.data_mem_resp), 32'(!model_last_data));
            end
            if (bus.instr_mem_resp && !i_done) begin
                i_hit = HOLD_EN && hold_valid && (hold_word == iw);
                checkOutput("instr_rdata", bus.instr_mem_rdata, ref_read(iw));
                if (!do_d || !d_done) begin
                    checkOutput("instr_latency", 32'(cyc), 32'(i_hit ? 1 : pmem_last_lat + 1));
                end
                if (!i_hit) begin
                    exp_pm++;
                    checkOutput("fetch_pmem_addr", pmem_last_addr, {iw, 2'b00});
                    checkOutput("fetch_pmem_mbe", 32'(pmem_last_mbe), 32'hF);
                    checkOutput("fetch_pmem_kind", 32'(pmem_last_write), 32'd0);
                end
                model_last_data = 1'b0;
                hold_valid      = 1'b1;
                hold_word       = iw;
                i_done          = 1'b1;
            end else begin
                checkOutput("instr_resp_quiet", 32'(bus.instr_mem_resp), 32'd0);
            end
            if (bus.data_mem_resp && !d_done) begin
                if (!do_i || !i_done || (bus.instr_mem_resp == 1'b0 && cyc == 0)) begin
                    if (!do_i) checkOutput("data_latency", 32'(cyc), 32'(pmem_last_lat + 1));
                end
                exp_pm++;
                checkOutput("data_pmem_addr", pmem_last_addr, {dw, 2'b00});
                checkOutput("data_pmem_kind", 32'(pmem_last_write), 32'(d_wr));
                if (d_wr) begin
                    checkOutput("store_wdata", pmem_last_wdata, d_wdata);
                    checkOutput("store_mbe", 32'(pmem_last_mbe), 32'(d_mbe));
                    ref_mem[dw] = merge(ref_read(dw), d_wdata, d_mbe);
                    if (hold_valid && hold_word == dw) hold_valid = 1'b0;
                end else begin
                    checkOutput("load_rdata", bus.data_mem_rdata, ref_read(dw));
                    checkOutput("load_mbe", 32'(pmem_last_mbe), 32'hF);
                end
                model_last_data = 1'b1;
                d_done          = 1'b1;
            end else begin
                checkOutput("data_resp_quiet", 32'(bus.data_mem_resp), 32'd0);
            end
            cyc++;
            @(posedge clk);
            #1;
            if (i_done) bus.instr_read = 1'b0;
            if (d_done) begin
                bus.data_read  = 1'b0;
                bus.data_write = 1'b0;
            end
        end
        checkOutput("round_done", 32'({i_done, d_done}), 32'd3);
        checkOutput("pmem_accesses", 32'(pmem_count - pm_before), 32'(exp_pm));
        if (!(i_done && d_done)) begin
            doReset();
        end else begin
            @(negedge clk);
            checkOutput("quiet_after", 32'({bus.instr_mem_resp, bus.data_mem_resp,
                                             bus.pmem_read, bus.pmem_write}), 32'd0);
        end
    endtask

    // Main sequence: reset, directed cases, then randomized rounds.
    initial begin : stimulus
        int          n, cyc, kind, ia, da;
        bit          wr;
        logic [31:0] wdata;
        logic [3:0]  mbe;

        rst = 1'b1;
        clearInputs();
        #2;
        rst = 1'b0;
        #1;
        checkIdle("por");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Single fetch of 0x60, memory answers 0x13 after three cycles.
        pmem_mem[30'h18] = 32'h0000_0013;
        ref_mem[30'h18]  = 32'h0000_0013;
        fixed_lat = 3;
        @(posedge clk);
        #1;
        bus.instr_read        = 1'b1;
        bus.instr_mem_address = 32'h60;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("fetch60_pmem_read", 32'(bus.pmem_read), 32'(c >= 1 && c <= 3));
            checkOutput("fetch60_instr_resp", 32'(bus.instr_mem_resp), 32'(c == 4));
            checkOutput("fetch60_data_resp", 32'(bus.data_mem_resp), 32'd0);
            if (c == 1) begin
                checkOutput("fetch60_pmem_addr", bus.pmem_address, 32'h60);
                checkOutput("fetch60_pmem_mbe", 32'(bus.pmem_mbe), 32'hF);
            end
            if (c == 4) checkOutput("fetch60_rdata", bus.instr_mem_rdata, 32'h13);
            @(posedge clk);
            #1;
            if (c == 4) bus.instr_read = 1'b0;
        end
        model_last_data = 1'b0;
        hold_valid      = 1'b1;
        hold_word       = 30'h18;

        // Byte store to 0x1003, top lane only.
        fixed_lat = 2;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1003, 32'hAB00_0000, 4'b1000);
        fixed_lat = 0;

        // Fetch and load together after reset, then both held: D, I, D, I.
        doReset();
        fixed_lat = 2;
        @(posedge clk);
        #1;
        bus.instr_read        = 1'b1;
        bus.instr_mem_address = 32'h0;
        bus.data_read         = 1'b1;
        bus.data_mem_address  = 32'h2000;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 80) begin
            @(negedge clk);
            if (bus.instr_mem_resp || bus.data_mem_resp) begin
                checkOutput("alt_grant", 32'(bus.data_mem_resp), 32'(!model_last_data));
                if (bus.data_mem_resp) begin
                    checkOutput("alt_load", bus.data_mem_rdata, ref_read(30'h800));
                    model_last_data = 1'b1;
                end else begin
                    checkOutput("alt_fetch", bus.instr_mem_rdata, ref_read(30'h0));
                    model_last_data = 1'b0;
                    hold_valid      = 1'b1;
                    hold_word       = 30'h0;
                end
                n++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        checkOutput("alt_count", 32'(n), 32'd4);
        clearInputs();
        @(negedge clk);
        checkOutput("alt_quiet", 32'({bus.instr_mem_resp, bus.data_mem_resp}), 32'd0);

        // Reset in the middle of a slow load aborts it without a response.
        fixed_lat = 10;
        @(posedge clk);
        #1;
        bus.data_read        = 1'b1;
        bus.data_mem_address = 32'h3000;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_pmem_read_before", 32'(bus.pmem_read), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_pmem_read_async", 32'(bus.pmem_read), 32'd0);
        checkOutput("abort_pmem_addr_async", bus.pmem_address, 32'd0);
        clearInputs();
        model_last_data = 1'b0;
        hold_valid      = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_data_resp", 32'(bus.data_mem_resp), 32'd0);
        end
        #2;
        rst = 1'b1;
        @(negedge clk);
        checkIdle("after_abort");
        fixed_lat = 0;

        // Repeated fetch of 0x60, a store to it, then another fetch.
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h60, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Randomized mix of fetches, loads, stores and simultaneous requests.
        for (int r = 0; r < 200; r++) begin
            kind  = int'($urandom_range(0, 2));
            ia    = int'($urandom_range(0, 7));
            da    = int'($urandom_range(0, 7));
            wr    = ($urandom_range(0, 2) == 0);
            wdata = $urandom;
            mbe   = 4'($urandom_range(0, 15));
            applyStimulus(kind != 1, pool[ia] | 32'($urandom_range(0, 3)),
                          kind != 0, wr, pool[da] | 32'($urandom_range(0, 3)),
                          wdata, mbe);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
